// File: rtl/hqm_aw_pkg.sv
// Shared helpers for the hqm_aw block family.
package hqm_aw_pkg;

    // Floor of log2; returns 0 for inputs of 0 or 1.
    function automatic int aw_logb2(input int value);
        int r;
        r = 0;
        for (int i = 1; i < 32; i++) begin
            if ((value >> i) != 0) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/hqm_aw_rr_binenc_core.sv
// Combinational masked priority search starting at ptr, in either direction,
// falling back to the unmasked vector when nothing lies at or beyond ptr.
module hqm_aw_rr_binenc_core
    import hqm_aw_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int MSB    = 0,
    parameter int EWIDTH = aw_logb2(WIDTH - 1) + 1
) (
    input  logic [WIDTH-1:0]  req,
    input  logic [EWIDTH-1:0] ptr,
    output logic [EWIDTH-1:0] winner,
    output logic [WIDTH-1:0]  onehot,
    output logic              any
);

    logic [WIDTH-1:0] masked;
    logic [WIDTH-1:0] search;

    // Keep only bits at or after ptr in the search direction.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
            if (MSB == 0) begin : g_asc
                assign masked[gi] = req[gi] & (EWIDTH'(gi) >= ptr);
            end else begin : g_desc
                assign masked[gi] = req[gi] & (EWIDTH'(gi) <= ptr);
            end
        end
    endgenerate

    assign search = (|masked) ? masked : req;
    assign any    = |req;

    // Later loop iterations overwrite earlier ones, so the iteration order
    // picks lowest-first (MSB=0) or highest-first (MSB=1).
    always_comb begin
        winner = '0;
        if (MSB == 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (search[i]) winner = EWIDTH'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (search[i]) winner = EWIDTH'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_onehot
            assign onehot[gi] = any & (winner == EWIDTH'(gi));
        end
    endgenerate

endmodule

// File: rtl/hqm_aw_rr_binenc.sv
// Registered round-robin / fixed priority encoder with a one-entry output
// stage and valid/ready handshakes on both sides.
module hqm_aw_rr_binenc
    import hqm_aw_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int MSB    = 0,
    parameter int RR     = 1,
    parameter int EWIDTH = aw_logb2(WIDTH - 1) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ptr_rst,
    input  logic              req_v,
    input  logic [WIDTH-1:0]  req,
    output logic              req_ready,
    output logic              out_v,
    input  logic              out_ready,
    output logic [EWIDTH-1:0] out_enc,
    output logic [WIDTH-1:0]  out_onehot,
    output logic              out_any
);

    localparam logic [EWIDTH-1:0] PTR_INIT = (MSB != 0) ? EWIDTH'(WIDTH - 1) : '0;
    localparam logic [EWIDTH-1:0] PTR_LAST = EWIDTH'(WIDTH - 1);

    logic [EWIDTH-1:0] ptr_reg, ptr_next;
    logic              out_v_reg;
    logic [EWIDTH-1:0] out_enc_reg;
    logic [WIDTH-1:0]  out_onehot_reg;
    logic              out_any_reg;

    logic [EWIDTH-1:0] winner;
    logic [WIDTH-1:0]  onehot;
    logic              any;
    logic              accept;

    hqm_aw_rr_binenc_core #(
        .WIDTH  (WIDTH),
        .MSB    (MSB),
        .EWIDTH (EWIDTH)
    ) u_core (
        .req    (req),
        .ptr    (ptr_reg),
        .winner (winner),
        .onehot (onehot),
        .any    (any)
    );

    assign req_ready = !out_v_reg | out_ready;
    assign accept    = req_v & req_ready;

    // Wrap explicitly at WIDTH-1 / 0 so non-power-of-2 widths stay in range.
    always_comb begin
        ptr_next = ptr_reg;
        if (ptr_rst) begin
            ptr_next = PTR_INIT;
        end else if ((RR != 0) && accept && any) begin
            if (MSB == 0) begin
                ptr_next = (winner == PTR_LAST) ? '0 : winner + EWIDTH'(1);
            end else begin
                ptr_next = (winner == '0) ? PTR_LAST : winner - EWIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg        <= PTR_INIT;
            out_v_reg      <= 1'b0;
            out_enc_reg    <= '0;
            out_onehot_reg <= '0;
            out_any_reg    <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
            if (accept) begin
                out_v_reg      <= 1'b1;
                out_enc_reg    <= winner;
                out_onehot_reg <= onehot;
                out_any_reg    <= any;
            end else if (out_ready) begin
                out_v_reg <= 1'b0;
            end
        end
    end

    assign out_v      = out_v_reg;
    assign out_enc    = out_enc_reg;
    assign out_onehot = out_onehot_reg;
    assign out_any    = out_any_reg;

endmodule

// File: tb/tb_hqm_aw_rr_binenc.sv
// Scoreboard bench: three WIDTH=5 encoders (ascending RR, descending RR,
// ascending fixed) run in lockstep on directed vectors.
module tb_hqm_aw_rr_binenc;

    typedef struct packed {
        logic [2:0] enc;
        logic [4:0] oh;
        logic       any;
        logic [2:0] ptr;
    } res_t;
    typedef res_t [2:0] trio_t;

    logic       clk = 1'b0;
    logic       rst, ptr_rst, req_v, out_ready;
    logic [4:0] ra, rb;

    logic       rdy_w [3];
    logic       ov_w  [3];
    logic [2:0] enc_w [3];
    logic [4:0] oh_w  [3];
    logic       any_w [3];
    logic [2:0] ptr_w [3];

    int    tests = 0;
    int    fails = 0;
    trio_t exp_q[$];
    trio_t last_t;

    always #5 clk = ~clk;

    hqm_aw_rr_binenc #(.WIDTH(5), .MSB(0), .RR(1)) d0 (
        .clk(clk), .rst(rst), .ptr_rst(ptr_rst), .req_v(req_v), .req(ra),
        .req_ready(rdy_w[0]), .out_v(ov_w[0]), .out_ready(out_ready),
        .out_enc(enc_w[0]), .out_onehot(oh_w[0]), .out_any(any_w[0]));

    hqm_aw_rr_binenc #(.WIDTH(5), .MSB(1), .RR(1)) d1 (
        .clk(clk), .rst(rst), .ptr_rst(ptr_rst), .req_v(req_v), .req(rb),
        .req_ready(rdy_w[1]), .out_v(ov_w[1]), .out_ready(out_ready),
        .out_enc(enc_w[1]), .out_onehot(oh_w[1]), .out_any(any_w[1]));

    hqm_aw_rr_binenc #(.WIDTH(5), .MSB(0), .RR(0)) d2 (
        .clk(clk), .rst(rst), .ptr_rst(ptr_rst), .req_v(req_v), .req(ra),
        .req_ready(rdy_w[2]), .out_v(ov_w[2]), .out_ready(out_ready),
        .out_enc(enc_w[2]), .out_onehot(oh_w[2]), .out_any(any_w[2]));

    always_comb begin
        ptr_w[0] = d0.ptr_reg;
        ptr_w[1] = d1.ptr_reg;
        ptr_w[2] = d2.ptr_reg;
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic res_t mk(input logic [2:0] e, input logic a, input logic [2:0] p);
        res_t r;
        r.enc = e;
        r.any = a;
        r.oh  = a ? (5'b00001 << e) : 5'b00000;
        r.ptr = p;
        return r;
    endfunction

    task automatic cmp_all(input string tag, input trio_t t);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s d%0d enc", tag, i), 8'(enc_w[i]), 8'(t[i].enc));
            chk($sformatf("%s d%0d onehot", tag, i), 8'(oh_w[i]), 8'(t[i].oh));
            chk($sformatf("%s d%0d any", tag, i), 8'(any_w[i]), 8'(t[i].any));
            chk($sformatf("%s d%0d ptr", tag, i), 8'(ptr_w[i]), 8'(t[i].ptr));
        end
    endtask

    // One accepted request: d0/d2 see a, d1 sees b; expected enc/ptr hand-computed.
    task automatic send(input logic [4:0] a, input logic [4:0] b,
                        input logic [2:0] e0, input logic [2:0] p0,
                        input logic [2:0] e1, input logic [2:0] p1,
                        input logic [2:0] e2, input logic pr);
        trio_t t;
        int    n;
        ra = a; rb = b; ptr_rst = pr; req_v = 1'b1;
        t[0] = mk(e0, |a, p0);
        t[1] = mk(e1, |b, p1);
        t[2] = mk(e2, |a, 3'd0);
        n = 0;
        @(negedge clk);
        while (!rdy_w[0] && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!rdy_w[0]) chk("accept timeout", 8'(rdy_w[0]), 8'd1);
        else exp_q.push_back(t);
        last_t = t;
        $display("[TB] send a=%b b=%b ptr_rst=%0b", a, b, pr);
        @(posedge clk);
        #1;
        req_v = 1'b0;
        ptr_rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && ov_w[0] && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected output", 8'd1, 8'd0);
            end else begin
                trio_t t;
                t = exp_q.pop_front();
                $display("[TB] result enc=%0d/%0d/%0d ptr=%0d/%0d/%0d",
                         enc_w[0], enc_w[1], enc_w[2], ptr_w[0], ptr_w[1], ptr_w[2]);
                cmp_all("out", t);
            end
        end
    end

    initial begin
        trio_t rz;
        int    n;
        rst = 1'b1; ptr_rst = 1'b0; req_v = 1'b0; out_ready = 1'b1;
        ra = '0; rb = '0;
        rz[0] = mk(3'd0, 1'b0, 3'd0);
        rz[1] = mk(3'd0, 1'b0, 3'd4);
        rz[2] = mk(3'd0, 1'b0, 3'd0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset d%0d out_v", i), 8'(ov_w[i]), 8'd0);
            chk($sformatf("reset d%0d req_ready", i), 8'(rdy_w[i]), 8'd1);
        end
        cmp_all("reset", rz);
        @(posedge clk);
        #1;

        // Rotating sequence: d0 1,2,4,1  d1 3,1,0,3
        send(5'b10110, 5'b01011, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 1'b0);
        send(5'b10110, 5'b01011, 3'd2, 3'd3, 3'd1, 3'd0, 3'd1, 1'b0);
        send(5'b10110, 5'b01011, 3'd4, 3'd0, 3'd0, 3'd4, 3'd1, 1'b0);
        send(5'b10110, 5'b01011, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 1'b0);
        // Grant bit 3 to move d0 ptr to 4
        send(5'b01000, 5'b01000, 3'd3, 3'd4, 3'd3, 3'd2, 3'd3, 1'b0);

        // Backpressure for 3 cycles while the next request waits
        out_ready = 1'b0;
        ra = 5'b00011; rb = 5'b00011; req_v = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("stall d%0d req_ready", i), 8'(rdy_w[i]), 8'd0);
                chk($sformatf("stall d%0d out_v", i), 8'(ov_w[i]), 8'd1);
            end
            cmp_all("stall", last_t);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;

        // Wrap at non-power-of-2 width: d0 ptr 4 -> enc 0, ptr 1
        send(5'b00011, 5'b00011, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 1'b0);
        // All-zero request
        send(5'b00000, 5'b00000, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 1'b0);
        // ptr_rst with accept: encode on old ptr, ptr returns to reset value
        send(5'b10110, 5'b00110, 3'd1, 3'd0, 3'd2, 3'd4, 3'd1, 1'b1);
        send(5'b10110, 5'b00110, 3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 1'b0);
        send(5'b00100, 5'b00100, 3'd2, 3'd3, 3'd2, 3'd1, 3'd2, 1'b0);

        // Hold that result, then reset while out_v=1 and out_ready=0
        out_ready = 1'b0;
        @(negedge clk);
        chk("held before rst out_v", 8'(ov_w[0]), 8'd1);
        cmp_all("held before rst", last_t);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("post-rst d%0d out_v", i), 8'(ov_w[i]), 8'd0);
            chk($sformatf("post-rst d%0d req_ready", i), 8'(rdy_w[i]), 8'd1);
        end
        cmp_all("post-rst", rz);
        @(posedge clk);
        #1 out_ready = 1'b1;

        send(5'b11000, 5'b11000, 3'd3, 3'd4, 3'd4, 3'd3, 3'd3, 1'b0);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            n++;
            @(posedge clk);
        end
        chk("drain", 8'(exp_q.size()), 8'd0);
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
